// File: rtl/gpr_file.sv
// rtl/gpr_file.sv - 32x32 MIPS GPR file plus HI/LO with same-cycle write-to-read bypass
// Written by the write-back stage, read combinationally by decode.
module gpr_file #(
   parameter int DW    = 32,
   parameter int AW    = 5,
   parameter int WB_WD = 1 + AW + DW,
   parameter int HL_WD = 2 + 2 * DW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WB_WD-1:0] wb_to_rf_bus,
   input  logic [HL_WD-1:0] wb_to_hilo_bus,
   input  logic [AW-1:0]    raddr1,
   output logic [DW-1:0]    rdata1,
   input  logic [AW-1:0]    raddr2,
   output logic [DW-1:0]    rdata2,
   output logic [DW-1:0]    hi_rdata,
   output logic [DW-1:0]    lo_rdata,
   output logic [31:0]      wr_count
);

   localparam int NREG = 1 << AW;

   logic          we;
   logic [AW-1:0] waddr;
   logic [DW-1:0] wdata;
   logic          hi_we;
   logic          lo_we;
   logic [DW-1:0] hi_wdata;
   logic [DW-1:0] lo_wdata;

   assign {we, waddr, wdata}                 = wb_to_rf_bus;
   assign {hi_we, lo_we, hi_wdata, lo_wdata} = wb_to_hilo_bus;

   logic [DW-1:0] regs_q [NREG];
   logic [DW-1:0] hi_q, hi_d;
   logic [DW-1:0] lo_q, lo_d;
   logic [31:0]   cnt_q, cnt_d;
   logic          gpr_wr;

   // A write to r0 or during reset neither commits nor bypasses.
   assign gpr_wr = we && (waddr != '0) && !rst;

   always_comb begin
      hi_d  = hi_we ? hi_wdata : hi_q;
      lo_d  = lo_we ? lo_wdata : lo_q;
      cnt_d = gpr_wr ? cnt_q + 32'd1 : cnt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
         hi_q  <= '0;
         lo_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (gpr_wr) begin
            regs_q[waddr] <= wdata;
         end
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      rdata1 = regs_q[raddr1];
      if (raddr1 == '0) begin
         rdata1 = '0;
      end else if (gpr_wr && (waddr == raddr1)) begin
         rdata1 = wdata;
      end
   end

   always_comb begin
      rdata2 = regs_q[raddr2];
      if (raddr2 == '0) begin
         rdata2 = '0;
      end else if (gpr_wr && (waddr == raddr2)) begin
         rdata2 = wdata;
      end
   end

   assign hi_rdata = (hi_we && !rst) ? hi_wdata : hi_q;
   assign lo_rdata = (lo_we && !rst) ? lo_wdata : lo_q;
   assign wr_count = cnt_q;

endmodule

// File: tb/tb_gpr_file.sv
// tb/tb_gpr_file.sv - scoreboard bench for gpr_file
// Expected read values come from a reference model and are queued as each cycle is driven.
module tb_gpr_file;

   logic        clk = 1'b0;
   logic        rst;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        hi_we, lo_we;
   logic [31:0] hi_wd, lo_wd;
   logic [4:0]  ra1, ra2;

   logic [37:0] wb_to_rf_bus;
   logic [65:0] wb_to_hilo_bus;
   logic [31:0] rdata1, rdata2, hi_rdata, lo_rdata, wr_count;

   assign wb_to_rf_bus   = {we, waddr, wdata};
   assign wb_to_hilo_bus = {hi_we, lo_we, hi_wd, lo_wd};

   gpr_file dut (
      .clk            (clk),
      .rst            (rst),
      .wb_to_rf_bus   (wb_to_rf_bus),
      .wb_to_hilo_bus (wb_to_hilo_bus),
      .raddr1         (ra1),
      .rdata1         (rdata1),
      .raddr2         (ra2),
      .rdata2         (rdata2),
      .hi_rdata       (hi_rdata),
      .lo_rdata       (lo_rdata),
      .wr_count       (wr_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [31:0] m_regs [32];
   logic [31:0] m_hi, m_lo, m_cnt;
   logic [31:0] exp_q [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (!rst && we && waddr == a) return wdata;
      return m_regs[a];
   endfunction

   task automatic sb_push();
      exp_q.push_back(exp_rd(ra1));
      exp_q.push_back(exp_rd(ra2));
      exp_q.push_back((!rst && hi_we) ? hi_wd : m_hi);
      exp_q.push_back((!rst && lo_we) ? lo_wd : m_lo);
      exp_q.push_back(m_cnt);
   endtask

   task automatic sb_pop_check();
      string       tags [5];
      logic [31:0] obs  [5];
      tags = '{"sb_rdata1", "sb_rdata2", "sb_hi", "sb_lo", "sb_cnt"};
      obs  = '{rdata1, rdata2, hi_rdata, lo_rdata, wr_count};
      for (int i = 0; i < 5; i++) begin
         chk(tags[i], obs[i], exp_q.pop_front());
      end
   endtask

   task automatic model_update();
      if (rst) begin
         for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
         m_hi  = 32'd0;
         m_lo  = 32'd0;
         m_cnt = 32'd0;
      end else begin
         if (we && waddr != 5'd0) begin
            m_regs[waddr] = wdata;
            m_cnt         = m_cnt + 32'd1;
         end
         if (hi_we) m_hi = hi_wd;
         if (lo_we) m_lo = lo_wd;
      end
   endtask

   // Inputs are changed at negedge; outputs checked mid-low phase, model advanced at posedge.
   task automatic tick();
      #2;
      sb_push();
      sb_pop_check();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic idle();
      we = 1'b0; waddr = '0; wdata = '0;
      hi_we = 1'b0; lo_we = 1'b0; hi_wd = '0; lo_wd = '0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'hFFFF_0000 + i;
      m_hi = 32'hBAD0_0001; m_lo = 32'hBAD0_0002; m_cnt = 32'hBAD0_0003;
      rst = 1'b1; ra1 = '0; ra2 = '0;
      idle();
      @(negedge clk);
      #2;
      @(posedge clk);
      model_update();
      @(negedge clk);
      rst = 1'b0;

      // reset clears preloaded state
      we = 1'b1; waddr = 5'd5; wdata = 32'h1234;
      hi_we = 1'b1; lo_we = 1'b1; hi_wd = 32'h55; lo_wd = 32'h66;
      tick();
      idle(); rst = 1'b1; ra1 = 5'd5;
      tick();
      rst = 1'b0;
      #1;
      chk("rst_r5", rdata1, 32'd0);
      chk("rst_hi", hi_rdata, 32'd0);
      chk("rst_lo", lo_rdata, 32'd0);
      chk("rst_cnt", wr_count, 32'd0);

      // write then read
      we = 1'b1; waddr = 5'd8; wdata = 32'hDEADBEEF;
      tick();
      idle(); ra1 = 5'd8;
      #1;
      chk("wr_r8", rdata1, 32'hDEADBEEF);
      chk("wr_cnt", wr_count, 32'd1);
      tick();

      // same-cycle bypass on both ports
      we = 1'b1; waddr = 5'd9; wdata = 32'hA5A5A5A5; ra1 = 5'd9; ra2 = 5'd9;
      #1;
      chk("byp_p1", rdata1, 32'hA5A5A5A5);
      chk("byp_p2", rdata2, 32'hA5A5A5A5);
      tick();
      idle();
      #1;
      chk("byp_hold", rdata1, 32'hA5A5A5A5);
      tick();

      // r0 is never written nor bypassed
      we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; ra1 = 5'd0;
      #1;
      chk("r0_same", rdata1, 32'd0);
      tick();
      idle();
      #1;
      chk("r0_next", rdata1, 32'd0);
      chk("r0_cnt", wr_count, 32'd2);
      tick();

      // HI/LO bypass, hold, and independent LO write
      hi_we = 1'b1; lo_we = 1'b1; hi_wd = 32'h1111; lo_wd = 32'h2222;
      #1;
      chk("hl_byp_hi", hi_rdata, 32'h1111);
      chk("hl_byp_lo", lo_rdata, 32'h2222);
      tick();
      idle();
      #1;
      chk("hl_hold_hi", hi_rdata, 32'h1111);
      chk("hl_hold_lo", lo_rdata, 32'h2222);
      tick();
      lo_we = 1'b1; lo_wd = 32'h3333;
      tick();
      idle();
      #1;
      chk("lo_only_hi", hi_rdata, 32'h1111);
      chk("lo_only_lo", lo_rdata, 32'h3333);
      tick();

      // write presented during reset is discarded
      rst = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'd7; ra1 = 5'd3;
      tick();
      rst = 1'b0; idle();
      #1;
      chk("rstw_r3", rdata1, 32'd0);
      chk("rstw_cnt", wr_count, 32'd0);
      tick();

      // randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         rst   = ($urandom_range(0, 49) == 0);
         we    = ($urandom_range(0, 3) != 0);
         waddr = 5'($urandom_range(0, 31));
         wdata = $urandom;
         hi_we = $urandom_range(0, 1) == 1;
         lo_we = $urandom_range(0, 1) == 1;
         hi_wd = $urandom;
         lo_wd = $urandom;
         ra1   = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom_range(0, 31));
         ra2   = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom_range(0, 31));
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
